// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx
//
// Serial bit-stream generator that feeds the one-hot serial sequence
// detectors. A frame is loaded through a valid/ready handshake. The frame is
// made of a pattern word, a length, a repeat count and a bit period. The
// pattern is sent MSB-first on w, one bit per bit period, for repeat+1 passes.
// Completion is reported with a one-cycle done pulse. An abort ends the frame
// early and is reported with a one-cycle aborted pulse.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   load_valid_i   request to start a frame
//   load_ready_o   block can accept a frame (idle and not in reset)
//   pattern_i      bits to send; pattern_i[length-1] goes out first
//   length_i       bits per pass; values above MAX_LEN clamp to MAX_LEN
//   repeat_i       extra passes; total passes = repeat_i + 1
//   bit_period_i   cycles each bit is held; 0 behaves like 1
//   abort_i        terminate the frame currently being sent
//   w_o            serial data bit (0 when not sending)
//   w_valid_o      w_o carries a frame bit
//   w_strobe_o     one-cycle pulse in the first cycle of every bit
//   busy_o         frame in progress
//   done_o         one-cycle pulse, frame completed normally
//   aborted_o      one-cycle pulse, frame terminated by abort
module serial_pattern_tx #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5,
    parameter int DIV_W   = 8,
    parameter int REP_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_valid_i,
    output logic               load_ready_o,
    input  logic [MAX_LEN-1:0] pattern_i,
    input  logic [LEN_W-1:0]   length_i,
    input  logic [REP_W-1:0]   repeat_i,
    input  logic [DIV_W-1:0]   bit_period_i,
    input  logic               abort_i,
    output logic               w_o,
    output logic               w_valid_o,
    output logic               w_strobe_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               aborted_o
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [IDX_W-1:0]   lastIdx_q, lastIdx_d;
    logic [DIV_W-1:0]   period_q, period_d;
    logic [IDX_W-1:0]   bitIdx_q, bitIdx_d;
    logic [DIV_W-1:0]   perCnt_q, perCnt_d;
    logic [REP_W-1:0]   passCnt_q, passCnt_d;
    logic               aborted_q, aborted_d;

    logic [LEN_W-1:0]   lenClamp;
    logic [DIV_W-1:0]   periodCap;
    logic               accept;

    // Input conditioning applied at the moment of capture: oversize lengths
    // clamp to the register width and a zero period behaves as one cycle.
    always_comb begin
        lenClamp  = (length_i > MAX_LEN_L) ? MAX_LEN_L : length_i;
        periodCap = (bit_period_i == '0) ? DIV_W'(1) : bit_period_i;
        accept    = load_valid_i && load_ready_o;
    end

    // State and datapath registers. Reset clears everything, which also
    // drops any frame in flight without a done or aborted pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            lastIdx_q <= '0;
            period_q  <= '0;
            bitIdx_q  <= '0;
            perCnt_q  <= '0;
            passCnt_q <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            lastIdx_q <= lastIdx_d;
            period_q  <= period_d;
            bitIdx_q  <= bitIdx_d;
            perCnt_q  <= perCnt_d;
            passCnt_q <= passCnt_d;
            aborted_q <= aborted_d;
        end
    end

    // Next-state logic. Three nested down-counters drive the frame: the
    // period counter (P-1..0) inside the bit index (len-1..0) inside the
    // pass counter (repeat..0). Each wraps only when it reads zero, so a new
    // pass restarts at the top bit with no idle cycle in between.
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        lastIdx_d = lastIdx_q;
        period_d  = period_q;
        bitIdx_d  = bitIdx_q;
        perCnt_d  = perCnt_q;
        passCnt_d = passCnt_q;
        aborted_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    pattern_d = pattern_i;
                    lastIdx_d = IDX_W'(lenClamp - LEN_W'(1));
                    period_d  = periodCap;
                    bitIdx_d  = IDX_W'(lenClamp - LEN_W'(1));
                    perCnt_d  = periodCap - DIV_W'(1);
                    passCnt_d = repeat_i;
                    state_d   = (lenClamp == '0) ? FINISH : SEND;
                end
            end

            SEND: begin
                if (abort_i) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (perCnt_q != '0) begin
                    perCnt_d = perCnt_q - DIV_W'(1);
                end else begin
                    perCnt_d = period_q - DIV_W'(1);
                    if (bitIdx_q != '0) begin
                        bitIdx_d = bitIdx_q - IDX_W'(1);
                    end else if (passCnt_q != '0) begin
                        passCnt_d = passCnt_q - REP_W'(1);
                        bitIdx_d  = lastIdx_q;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode. The strobe marks the cycle right after the period
    // counter was reloaded, which is the first cycle of each bit.
    always_comb begin
        load_ready_o = (state_q == IDLE) && !reset;
        busy_o       = (state_q != IDLE);
        done_o       = (state_q == FINISH);
        aborted_o    = aborted_q;
        w_valid_o    = (state_q == SEND);
        w_strobe_o   = (state_q == SEND) && (perCnt_q == period_q - DIV_W'(1));
        w_o          = (state_q == SEND) ? pattern_q[bitIdx_q] : 1'b0;
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx.
// Outputs are packed as {load_ready, busy, done, aborted, w_valid, w_strobe, w}.
module tb_serial_pattern_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid_i;
    logic        load_ready_o;
    logic [15:0] pattern_i;
    logic [4:0]  length_i;
    logic [3:0]  repeat_i;
    logic [7:0]  bit_period_i;
    logic        abort_i;
    logic        w_o;
    logic        w_valid_o;
    logic        w_strobe_o;
    logic        busy_o;
    logic        done_o;
    logic        aborted_o;

    int nChecks = 0;
    int nFails  = 0;

    localparam logic [6:0] IDLE_RDY = 7'b1000000;
    localparam logic [6:0] FIN_EXP  = 7'b0110000;
    localparam logic [6:0] ALL_ZERO = 7'b0000000;

    typedef struct {
        logic [15:0] pattern;
        logic [4:0]  len;
        logic [3:0]  rep;
        logic [7:0]  period;
        int          expValid;
        int          expOnes;
    } vec_t;

    vec_t vecs[8];

    serial_pattern_tx dut (
        .clk          (clk),
        .reset        (reset),
        .load_valid_i (load_valid_i),
        .load_ready_o (load_ready_o),
        .pattern_i    (pattern_i),
        .length_i     (length_i),
        .repeat_i     (repeat_i),
        .bit_period_i (bit_period_i),
        .abort_i      (abort_i),
        .w_o          (w_o),
        .w_valid_o    (w_valid_o),
        .w_strobe_o   (w_strobe_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .aborted_o    (aborted_o)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] obs();
        return {load_ready_o, busy_o, done_o, aborted_o, w_valid_o, w_strobe_o, w_o};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [6:0] act, input logic [6:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s at %0t: got %b expected %b (rdy,busy,done,abrt,wv,ws,w)",
                     name, $time, act, exp);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Loads one frame and follows it to the idle cycle after done. The
    // expected waveform is built from the frame rules: passes x bits x period.
    task automatic applyStimulus(input logic [15:0] pat, input logic [4:0] len,
                                 input logic [3:0] rep, input logic [7:0] per,
                                 output int vCnt, output int oCnt);
        logic [2:0] q[$];
        int effLen;
        int effP;
        effLen = (len > 5'd16) ? 16 : int'(len);
        effP   = (per == 8'd0) ? 1 : int'(per);
        for (int p = 0; p <= int'(rep); p++)
            for (int b = effLen - 1; b >= 0; b--)
                for (int c = 0; c < effP; c++)
                    q.push_back({1'b1, (c == 0), pat[b]});
        vCnt = 0;
        oCnt = 0;
        checkOutput("ready_before", obs(), IDLE_RDY);
        pattern_i    = pat;
        length_i     = len;
        repeat_i     = rep;
        bit_period_i = per;
        load_valid_i = 1'b1;
        step();
        load_valid_i = 1'b0;
        pattern_i    = 16'($urandom);
        length_i     = 5'($urandom);
        repeat_i     = 4'($urandom);
        bit_period_i = 8'($urandom);
        for (int i = 0; i < q.size(); i++) begin
            checkOutput("send_bit", obs(), {4'b0100, q[i]});
            if (w_valid_o) vCnt++;
            if (w_valid_o && w_o) oCnt++;
            step();
        end
        checkOutput("finish", obs(), FIN_EXP);
        step();
        checkOutput("idle_after", obs(), IDLE_RDY);
    endtask

    initial begin
        int vCnt;
        int oCnt;
        logic [15:0] pat;

        vecs[0] = '{16'h000B,  5'd4, 4'd0, 8'd1,  4,  3};
        vecs[1] = '{16'h0006,  5'd3, 4'd0, 8'd3,  9,  6};
        vecs[2] = '{16'h0001,  5'd2, 4'd2, 8'd1,  6,  3};
        vecs[3] = '{16'h0001,  5'd2, 4'd2, 8'd0,  6,  3};
        vecs[4] = '{16'h1234,  5'd0, 4'd3, 8'd5,  0,  0};
        vecs[5] = '{16'h8001, 5'd20, 4'd0, 8'd1, 16,  2};
        vecs[6] = '{16'hFFFF, 5'd16, 4'd1, 8'd2, 64, 64};
        vecs[7] = '{16'h00A5,  5'd8, 4'd0, 8'd1,  8,  4};

        reset        = 1'b1;
        load_valid_i = 1'b0;
        pattern_i    = '0;
        length_i     = '0;
        repeat_i     = '0;
        bit_period_i = '0;
        abort_i      = 1'b0;
        step();
        checkOutput("reset_state", obs(), ALL_ZERO);
        reset = 1'b0;
        #1;
        checkOutput("ready_after_reset", obs(), IDLE_RDY);

        // Table-driven frames.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].pattern, vecs[i].len, vecs[i].rep, vecs[i].period, vCnt, oCnt);
            checkInt($sformatf("valid_cycles_%0d", i), vCnt, vecs[i].expValid);
            checkInt($sformatf("ones_%0d", i), oCnt, vecs[i].expOnes);
        end

        // Abort during SEND at cycle 5, new load accepted in cycle 6.
        pat          = 16'($urandom);
        pattern_i    = pat;
        length_i     = 5'd8;
        repeat_i     = 4'd0;
        bit_period_i = 8'd2;
        load_valid_i = 1'b1;
        step();
        load_valid_i = 1'b0;
        for (int c = 1; c < 5; c++) step();
        checkOutput("abort_c5", obs(), {6'b010011, pat[5]});
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        checkOutput("abort_c6", obs(), 7'b1001000);
        pattern_i    = 16'h0001;
        length_i     = 5'd1;
        bit_period_i = 8'd1;
        load_valid_i = 1'b1;
        step();
        load_valid_i = 1'b0;
        checkOutput("reload_c7", obs(), 7'b0100111);
        step();
        checkOutput("reload_finish", obs(), FIN_EXP);
        // Abort during FINISH and IDLE must do nothing.
        abort_i = 1'b1;
        step();
        checkOutput("abort_in_finish", obs(), IDLE_RDY);
        step();
        checkOutput("abort_in_idle", obs(), IDLE_RDY);
        abort_i = 1'b0;

        // Reset mid-frame drops the frame silently.
        pattern_i    = 16'hFFFF;
        length_i     = 5'd16;
        bit_period_i = 8'd3;
        load_valid_i = 1'b1;
        step();
        load_valid_i = 1'b0;
        for (int c = 1; c < 5; c++) step();
        reset = 1'b1;
        #1;
        checkOutput("reset_cycle_mid", obs(), 7'b0100101);
        step();
        reset = 1'b0;
        #1;
        checkOutput("post_reset_1", obs(), IDLE_RDY);
        step();
        checkOutput("post_reset_2", obs(), IDLE_RDY);

        // load_valid held high: one accept per frame, next one after done.
        pattern_i    = 16'h0002;
        length_i     = 5'd2;
        repeat_i     = 4'd0;
        bit_period_i = 8'd1;
        load_valid_i = 1'b1;
        step();
        checkOutput("held_c1", obs(), 7'b0100111);
        step();
        checkOutput("held_c2", obs(), 7'b0100110);
        step();
        checkOutput("held_c3", obs(), FIN_EXP);
        step();
        checkOutput("held_c4", obs(), IDLE_RDY);
        step();
        load_valid_i = 1'b0;
        checkOutput("held_c5", obs(), 7'b0100111);
        step();
        checkOutput("held_c6", obs(), 7'b0100110);
        step();
        checkOutput("held_c7", obs(), FIN_EXP);
        step();
        checkOutput("held_c8", obs(), IDLE_RDY);

        // Randomized frames against the reference model.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(16'($urandom), 5'($urandom_range(0, 20)), 4'($urandom_range(0, 3)),
                          8'($urandom_range(0, 4)), vCnt, oCnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
Serial bit-stream generator. It is the transmit side for the team's one-hot serial sequence detectors: it produces the single-bit `w` stream that a detector consumes, one bit per bit period, with a strobe marking each new bit. A pattern word, its length, a repeat count and a bit period are loaded through a valid/ready handshake. The block then shifts the pattern out MSB-first and reports completion. It replaces hand-toggled switch stimulus in lab test setups.

Parameters:
MAX_LEN, 16, pattern register width (max bits per pass)
LEN_W, 5, width of length input; must hold MAX_LEN
DIV_W, 8, width of bit_period input and per-bit cycle counter
REP_W, 4, width of repeat input

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
load_valid  in  1  request to start a frame
load_ready  out  1  block can accept a frame
pattern  in  MAX_LEN  bits to send; pattern[length-1] sent first
length  in  LEN_W  bits per pass; values >MAX_LEN clamp to MAX_LEN
repeat  in  REP_W  extra passes; total passes = repeat+1
bit_period  in  DIV_W  cycles each bit is held; 0 treated as 1
abort  in  1  terminate current frame
w  out  1  serial data bit
w_valid  out  1  w carries a frame bit
w_strobe  out  1  1-cycle pulse in the first cycle of each bit
busy  out  1  frame in progress (state != IDLE)
done  out  1  1-cycle pulse, frame completed normally
aborted  out  1  1-cycle pulse, frame terminated by abort

Behaviour:
- Interface: one clock `clk`. Reset is synchronous and active-high (`reset`); it is sampled only on a rising clk edge.
- States: IDLE, SEND, FINISH.
- Reset (any state): next state IDLE. w, w_valid, w_strobe, busy, done and aborted are all 0. Internal counters and shift register clear. load_ready = (state==IDLE) & ~reset, so it is 0 during the reset cycle and 1 in the first cycle after.
- IDLE: load_ready=1, w=0 (idle level), w_valid=0.
  - Accept occurs on the edge where load_valid & load_ready.
  - On accept, capture pattern, clamped length, repeat and max(bit_period,1). Later input changes are ignored until the next accept.
- Accept with length==0: go to FINISH. No bits are sent.
- Accept with length>0: go to SEND.
- SEND:
  - The cycle after accept: w = pattern[len-1], w_valid=1, w_strobe=1.
  - Each bit is held for P cycles (P = captured period). w_strobe is high only in the first of those P cycles.
  - Bits advance MSB to LSB through the pattern, one per P cycles.
  - After bit 0 of a pass, the next pass starts immediately at bit len-1. There is no gap cycle between passes.
  - After bit 0 of the final pass has been held P cycles, go to FINISH.
  - Total w_valid-high cycles = len*(repeat+1)*P.
- FINISH: lasts exactly 1 cycle. done=1 (normal completion), w_valid=0, w=0, load_ready=0. Next state IDLE.
- abort in SEND: sampled on an edge, it forces next state IDLE.
  - Next cycle: w_valid=0, w=0, aborted=1 for 1 cycle, done stays 0, load_ready=1.
  - abort in IDLE or FINISH has no effect. The FINISH cycle still completes normally.
- load_valid while busy: ignored, not queued.
- reset mid-frame: frame is dropped, no done and no aborted pulse. After reset the block is ready to accept.
- done and aborted are never high in the same cycle.
- Counters:
  - Bit index counts down from len-1.
  - Period counter counts P-1 down to 0.
  - Pass counter counts down from repeat.
  - All wrap conditions are decided by comparison with 0, never by overflow.

Test Plan:
- Reset, then load pattern=16'h000B, length=4, period=1, repeat=0 -> cycles 1..4 after accept show w=1,0,1,1 with w_valid=1 and w_strobe=1 each cycle; done=1 at cycle 5; load_ready=1 at cycle 6.
- pattern=3'b110, length=3, period=3 -> w=1 for cycles 1-3, 1 for 4-6, 0 for 7-9; w_strobe only at cycles 1, 4, 7; done at cycle 10.
- pattern=2'b01, length=2, repeat=2, period=1 -> w=0,1,0,1,0,1 in cycles 1-6 with no gap; done at cycle 7; period 0 gives an identical waveform.
- length=8, period=2, abort asserted at cycle 5 -> cycle 6 shows w_valid=0, aborted=1, done=0, load_ready=1; a new load is accepted at cycle 6.
- length=0 -> no w_valid, done at cycle 1. length=20 with pattern=16'h8001 -> 16 bits sent starting with 1 and ending with 1; done at cycle 17.
- reset asserted mid-frame -> next cycle all outputs 0, no done or aborted. load_valid held high throughout a busy frame -> exactly one accept per frame; the second accept occurs the cycle after done.
